invaders: RTL and testbench

INVADERS -- requirements
Module: invaders

---
 rtl/invaders.sv | 57 +++++
 tb/tb_invaders.sv | 129 ++++++++++++
 2 files changed

// File: rtl/invaders.sv
// invaders: marching invader formation with bullet hits; define INVADERS_DESCEND_EN to descend a row on each edge turn
module invaders #(
  parameter logic [31:0] TICK_CYCLES = 32'd18000000
) (
  input  logic        i_clk_36MHz,
  input  logic        i_reset,
  input  logic [4:0]  i_bullet_x,
  input  logic [3:0]  i_bullet_y,
  output logic        o_hit,
  output logic [19:0] o_invaders_array,
  output logic [3:0]  o_invaders_row
);
  logic [31:0] count;
  logic        o_q;
  logic        direction;
  logic        hit_r;
  logic [19:0] array_r;
  logic [3:0]  row_r;
  logic [19:0] bullet_mask, cleared, moved, array_next;
  logic        hit, lead, alive, dir_next;
  logic [3:0]  row_next;
  always_comb begin
    bullet_mask = i_bullet_x < 5'd20 ? 20'd1 << i_bullet_x : 20'd0;
    hit = i_bullet_y == row_r && |(array_r & bullet_mask);
    cleared = hit ? array_r & ~bullet_mask : array_r;
    alive = |cleared;
    lead = direction ? cleared[0] : cleared[19];
    moved = direction ? cleared >> 1 : cleared << 1;
    array_next = o_q && alive && !lead ? moved : cleared;
    dir_next = direction ^ (o_q && alive && lead);
`ifdef INVADERS_DESCEND_EN
    row_next = o_q && alive && lead && row_r != 4'd15 ? row_r + 4'd1 : row_r;
`else
    row_next = row_r;
`endif
  end
  always_ff @(posedge i_clk_36MHz) begin
    if (i_reset) begin
      count     <= 32'd0;
      o_q       <= 1'b0;
      direction <= 1'b0;
      hit_r     <= 1'b0;
      array_r   <= 20'h001ff;
      row_r     <= 4'd1;
    end else begin
      count     <= count == TICK_CYCLES - 32'd1 ? 32'd0 : count + 32'd1;
      o_q       <= count == TICK_CYCLES - 32'd1;
      direction <= dir_next;
      hit_r     <= hit;
      array_r   <= array_next;
      row_r     <= row_next;
    end
  end
  assign o_hit = hit_r;
  assign o_invaders_array = array_r;
  assign o_invaders_row = row_r;
endmodule

// File: tb/tb_invaders.sv
// tb_invaders: directed and randomized checks of invaders against a behavioural formation model
module tb_invaders;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [4:0]  i_bullet_x = 5'd31;
  logic [3:0]  i_bullet_y = 4'd0;
  logic        o_hit;
  logic [19:0] o_invaders_array;
  logic [3:0]  o_invaders_row;
  int tests = 0;
  int fails = 0;
  int m_arr, m_row, m_k;
  bit m_dir, m_hit;
`ifdef INVADERS_DESCEND_EN
  localparam int TURN_ROW = 2;
`else
  localparam int TURN_ROW = 1;
`endif
  invaders #(.TICK_CYCLES(32'd4)) dut (
    .i_clk_36MHz(clk),
    .i_reset(i_reset),
    .i_bullet_x(i_bullet_x),
    .i_bullet_y(i_bullet_y),
    .o_hit(o_hit),
    .o_invaders_array(o_invaders_array),
    .o_invaders_row(o_invaders_row)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_step(input int bx, input int by, input bit r);
    bit tick, lead;
    if (r) begin
      m_arr = 'h1ff;
      m_row = 1;
      m_dir = 0;
      m_hit = 0;
      m_k = 0;
    end else begin
      tick = m_k > 0 && m_k % 4 == 0;
      m_hit = bx < 20 && by == m_row && ((m_arr >> bx) % 2) == 1;
      if (m_hit) m_arr = m_arr - (1 << bx);
      if (tick && m_arr != 0) begin
        lead = m_dir ? (m_arr % 2 == 1) : (m_arr >= (1 << 19));
        if (lead) begin
          m_dir = !m_dir;
`ifdef INVADERS_DESCEND_EN
          if (m_row < 15) m_row = m_row + 1;
`endif
        end else begin
          m_arr = m_dir ? m_arr / 2 : m_arr * 2;
        end
      end
      m_k = m_k + 1;
    end
  endtask
  task automatic step(input int bx, input int by, input bit r);
    i_bullet_x = 5'(bx);
    i_bullet_y = 4'(by);
    i_reset = r;
    model_step(bx, by, r);
    @(posedge clk);
    #1;
    chk("array", 32'(o_invaders_array), 32'(m_arr));
    chk("row", 32'(o_invaders_row), 32'(m_row));
    chk("hit", 32'(o_hit), 32'(m_hit));
    chk("dir", 32'(dut.direction), 32'(m_dir));
    chk("tick", 32'(dut.o_q), 32'(m_k > 0 && m_k % 4 == 0));
  endtask
  initial begin
    int bx, by;
    bit r;
    step(0, 0, 1);
    chk("reset_array", 32'(o_invaders_array), 32'h1ff);
    chk("reset_row", 32'(o_invaders_row), 32'd1);
    chk("reset_hit", 32'(o_hit), 32'd0);
    for (int n = 1; n <= 53; n++) begin
      step(31, 0, 0);
      if (n == 3) chk("q_before", 32'(dut.o_q), 32'd0);
      if (n == 4) chk("q_first", 32'(dut.o_q), 32'd1);
      if (n == 5) chk("tick1_array", 32'(o_invaders_array), 32'h3fe);
      if (n == 45) chk("tick11_array", 32'(o_invaders_array), 32'hff800);
      if (n == 49) begin
        chk("tick12_array", 32'(o_invaders_array), 32'hff800);
        chk("tick12_dir", 32'(dut.direction), 32'd1);
        chk("tick12_row", 32'(o_invaders_row), 32'(TURN_ROW));
      end
      if (n == 53) chk("tick13_array", 32'(o_invaders_array), 32'h7fc00);
    end
    step(31, 0, 1);
    chk("midreset_array", 32'(o_invaders_array), 32'h1ff);
    chk("midreset_row", 32'(o_invaders_row), 32'd1);
    chk("midreset_dir", 32'(dut.direction), 32'd0);
    chk("midreset_hit", 32'(o_hit), 32'd0);
    step(3, 1, 0);
    chk("hit_pulse", 32'(o_hit), 32'd1);
    chk("hit_array", 32'(o_invaders_array), 32'h1f7);
    step(3, 1, 0);
    chk("hit_hold", 32'(o_hit), 32'd0);
    step(3, 1, 0);
    step(31, 0, 1);
    step(3, 2, 0);
    chk("miss_row", 32'(o_invaders_array), 32'h1ff);
    step(25, 1, 0);
    chk("miss_range", 32'(o_hit), 32'd0);
    step(12, 1, 0);
    chk("miss_empty", 32'(o_invaders_array), 32'h1ff);
    step(31, 0, 1);
    for (int n = 0; n < 4; n++) step(31, 0, 0);
    step(8, 1, 0);
    chk("coincide_array", 32'(o_invaders_array), 32'h1fe);
    chk("coincide_hit", 32'(o_hit), 32'd1);
    step(31, 0, 1);
    for (int n = 0; n < 800; n++) step(31, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom % 200) == 0;
      bx = int'($urandom % 32);
      by = ($urandom % 3 == 0) ? m_row : int'($urandom % 16);
      step(bx, by, r);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
